// File: rtl/bmd_64_wdma_engine.sv
// bmd_64_wdma_engine
// Write-DMA TLP engine. It takes a start pulse with a 64-bit bus address and a
// DW length. It drains 64-bit words from a first-word-fall-through FIFO and emits
// posted Memory Write TLPs on the 64-bit TRN TX interface, split at
// MAX_PAYLOAD_DW. wdma_done_o stays high until the DMA FSM re-arms the engine
// through wdma_rst_o.
module bmd_64_wdma_engine #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int LEN_W          = 32
) (
  input  logic             clk,
  input  logic             wdma_rst_o,
  input  logic             wdma_start_i,
  input  logic [63:0]      wdma_addr_i,
  input  logic [LEN_W-1:0] wdma_len_i,
  input  logic [15:0]      completer_id_i,
  output logic             wdma_done_o,
  output logic [15:0]      wdma_tlp_cnt_o,
  input  logic [63:0]      data_i,
  input  logic             data_empty_i,
  output logic             data_rd_o,
  output logic [63:0]      trn_td_o,
  output logic [7:0]       trn_trem_n_o,
  output logic             trn_tsof_n_o,
  output logic             trn_teof_n_o,
  output logic             trn_tsrc_rdy_n_o,
  input  logic             trn_tdst_rdy_n_i
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MPS = LEN_W'(MAX_PAYLOAD_DW);

  state_t           state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [15:0]      tlp_cnt_q, tlp_cnt_d;
  logic [7:0]       beat_q, beat_d;      // DATA beats already sent in this TLP
  logic [31:0]      held_q, held_d;      // 3DW skid: lower DW of the last popped word

  logic [LEN_W-1:0] pl_s;
  logic [LEN_W-1:0] last_beat_s;
  logic             fmt4_s;
  logic             is_last_s;
  logic             xfer_s;
  logic [31:0]      dw0_s;
  logic [31:0]      dw1_s;

  // Payload of the current TLP. remaining_q only changes at EOF, so this stays
  // constant for the whole TLP.
  assign pl_s        = (remaining_q < MPS) ? remaining_q : MPS;
  // A 3DW TLP has the same DATA beat count as a 4DW TLP: pl/2, counting the
  // trailing half beat.
  assign last_beat_s = (pl_s >> 1) - LEN_W'(1);
  assign is_last_s   = (LEN_W'(beat_q) == last_beat_s);
  assign fmt4_s      = |addr_q[63:32];
  assign xfer_s      = ~trn_tsrc_rdy_n_o & ~trn_tdst_rdy_n_i;

  assign dw0_s = {1'b0, (fmt4_s ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'b0000,
                  1'b0, 1'b0, 2'b00, 2'b00, pl_s[9:0]};
  assign dw1_s = {completer_id_i, 8'h00, 4'hF, 4'hF};

  assign wdma_done_o    = (state_q == ST_DONE);
  assign wdma_tlp_cnt_o = tlp_cnt_q;

  // State register with asynchronous re-arm from the DMA FSM
  always_ff @(posedge clk or posedge wdma_rst_o) begin
    if (wdma_rst_o) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: address, remaining length, counters and the skid DW
  always_ff @(posedge clk or posedge wdma_rst_o) begin
    if (wdma_rst_o) begin
      addr_q      <= 64'h0;
      remaining_q <= '0;
      tlp_cnt_q   <= 16'h0;
      beat_q      <= 8'h0;
      held_q      <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tlp_cnt_q   <= tlp_cnt_d;
      beat_q      <= beat_d;
      held_q      <= held_d;
    end
  end

  // Next-state and datapath update; nothing advances without an accepted beat
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    tlp_cnt_d   = tlp_cnt_q;
    beat_d      = beat_q;
    held_d      = held_q;
    case (state_q)
      ST_IDLE: begin
        if (wdma_start_i) begin
          addr_d      = wdma_addr_i;
          remaining_d = wdma_len_i;
          tlp_cnt_d   = 16'h0;
          beat_d      = 8'h0;
          state_d     = (wdma_len_i == '0) ? ST_DONE : ST_HDR0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR0: begin
        if (xfer_s) begin
          state_d = ST_HDR1;
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (xfer_s) begin
          beat_d  = 8'h0;
          state_d = ST_DATA;
          if (!fmt4_s) begin
            held_d = data_i[31:0];
          end else begin
            held_d = held_q;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_DATA: begin
        if (xfer_s && is_last_s) begin
          // The 64-bit add lets a carry into the upper word switch to 4DW
          addr_d      = addr_q + (64'(pl_s) << 2);
          remaining_d = remaining_q - pl_s;
          tlp_cnt_d   = tlp_cnt_q + 16'd1;
          beat_d      = 8'h0;
          state_d     = (remaining_q == pl_s) ? ST_DONE : ST_HDR0;
        end else if (xfer_s) begin
          beat_d = beat_q + 8'd1;
          if (!fmt4_s) begin
            held_d = data_i[31:0];
          end else begin
            held_d = held_q;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // TRN beat and FIFO pop decode. A beat that needs data waits for a non-empty FIFO.
  always_comb begin
    trn_td_o         = 64'h0;
    trn_trem_n_o     = 8'h00;
    trn_tsof_n_o     = 1'b1;
    trn_teof_n_o     = 1'b1;
    trn_tsrc_rdy_n_o = 1'b1;
    data_rd_o        = 1'b0;
    case (state_q)
      ST_HDR0: begin
        trn_td_o         = {dw0_s, dw1_s};
        trn_tsof_n_o     = 1'b0;
        trn_tsrc_rdy_n_o = 1'b0;
      end
      ST_HDR1: begin
        if (fmt4_s) begin
          trn_td_o         = {addr_q[63:32], addr_q[31:2], 2'b00};
          trn_tsrc_rdy_n_o = 1'b0;
        end else begin
          trn_td_o         = {addr_q[31:2], 2'b00, data_i[63:32]};
          trn_tsrc_rdy_n_o = data_empty_i;
          data_rd_o        = ~data_empty_i & ~trn_tdst_rdy_n_i;
        end
      end
      ST_DATA: begin
        if (fmt4_s) begin
          trn_td_o         = data_i;
          trn_teof_n_o     = ~is_last_s;
          trn_tsrc_rdy_n_o = data_empty_i;
          data_rd_o        = ~data_empty_i & ~trn_tdst_rdy_n_i;
        end else if (is_last_s) begin
          trn_td_o         = {held_q, 32'h0};
          trn_trem_n_o     = 8'h0F;
          trn_teof_n_o     = 1'b0;
          trn_tsrc_rdy_n_o = 1'b0;
        end else begin
          trn_td_o         = {held_q, data_i[63:32]};
          trn_tsrc_rdy_n_o = data_empty_i;
          data_rd_o        = ~data_empty_i & ~trn_tdst_rdy_n_i;
        end
      end
      default: begin
        trn_td_o = 64'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_bmd_64_wdma_engine.sv
// Testbench for bmd_64_wdma_engine. It runs a table of directed transfers,
// randomized transfers and a few hand-written control sequences. Expected beats
// come from a reference model that assembles each TLP as a DW list and packs
// it two DWs per beat.
module tb_bmd_64_wdma_engine;

  localparam int MPS    = 32;
  localparam int BUDGET = 3000;
  localparam logic [15:0] CID = 16'hBEEF;

  logic        clk = 1'b0;
  logic        wdma_rst_o;
  logic        wdma_start_i;
  logic [63:0] wdma_addr_i;
  logic [31:0] wdma_len_i;
  logic        wdma_done_o;
  logic [15:0] wdma_tlp_cnt_o;
  logic [63:0] data_i;
  logic        data_empty_i;
  logic        data_rd_o;
  logic [63:0] trn_td_o;
  logic [7:0]  trn_trem_n_o;
  logic        trn_tsof_n_o;
  logic        trn_teof_n_o;
  logic        trn_tsrc_rdy_n_o;
  logic        trn_tdst_rdy_n_i;

  always #5 clk = ~clk;

  bmd_64_wdma_engine #(.MAX_PAYLOAD_DW(MPS), .LEN_W(32)) dut (
    .clk              (clk),
    .wdma_rst_o       (wdma_rst_o),
    .wdma_start_i     (wdma_start_i),
    .wdma_addr_i      (wdma_addr_i),
    .wdma_len_i       (wdma_len_i),
    .completer_id_i   (CID),
    .wdma_done_o      (wdma_done_o),
    .wdma_tlp_cnt_o   (wdma_tlp_cnt_o),
    .data_i           (data_i),
    .data_empty_i     (data_empty_i),
    .data_rd_o        (data_rd_o),
    .trn_td_o         (trn_td_o),
    .trn_trem_n_o     (trn_trem_n_o),
    .trn_tsof_n_o     (trn_tsof_n_o),
    .trn_teof_n_o     (trn_teof_n_o),
    .trn_tsrc_rdy_n_o (trn_tsrc_rdy_n_o),
    .trn_tdst_rdy_n_i (trn_tdst_rdy_n_i)
  );

  typedef struct {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof;
    logic        eof;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          stall;
    int          empty;
    bit          inject;
    int          exp_tlps;
    int          exp_beats;
    logic [63:0] exp_first;
  } vec_t;

  beat_t       exp_q[$];
  logic [63:0] fifo_q[$];
  logic [63:0] pend_q[$];
  int          checks   = 0;
  int          passed   = 0;
  int          pat_n    = 0;
  bit          pop_pend = 1'b0;

  function automatic logic [31:0] pat_dw(input int n);
    return {16'hA5C3 ^ n[15:0], n[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {59'h0, wdma_done_o, data_rd_o, trn_tsrc_rdy_n_o, trn_tsof_n_o, trn_teof_n_o},
        64'h7);
    chk({tag, "_td"}, trn_td_o, 64'h0);
    chk({tag, "_trem"}, {56'h0, trn_trem_n_o}, 64'h0);
    chk({tag, "_tlpcnt"}, {48'h0, wdma_tlp_cnt_o}, 64'h0);
  endtask

  // Build the expected beat stream and the FIFO contents for one transfer
  task automatic build_model(input logic [63:0] a, input int len, output int n_tlp);
    logic [63:0] cur;
    logic [31:0] d;
    logic [31:0] dws[$];
    logic [31:0] pay[$];
    beat_t       b;
    int          rem;
    int          pl;
    cur   = a;
    rem   = len;
    n_tlp = 0;
    while (rem > 0) begin
      pl = (rem < MPS) ? rem : MPS;
      dws.delete();
      if (cur[63:32] != 32'h0) begin
        dws.push_back(32'h6000_0000 | 32'(pl));
        dws.push_back({CID, 8'h00, 8'hFF});
        dws.push_back(cur[63:32]);
        dws.push_back({cur[31:2], 2'b00});
      end else begin
        dws.push_back(32'h4000_0000 | 32'(pl));
        dws.push_back({CID, 8'h00, 8'hFF});
        dws.push_back({cur[31:2], 2'b00});
      end
      for (int i = 0; i < pl; i++) begin
        d = pat_dw(pat_n);
        pat_n++;
        dws.push_back(d);
        pay.push_back(d);
      end
      for (int i = 0; i < dws.size(); i += 2) begin
        b.sof = (i != 0);
        b.eof = (i + 2 < dws.size());
        if (i + 1 < dws.size()) begin
          b.td   = {dws[i], dws[i+1]};
          b.trem = 8'h00;
        end else begin
          b.td   = {dws[i], 32'h0};
          b.trem = 8'h0F;
        end
        exp_q.push_back(b);
      end
      cur = cur + 64'(pl) * 64'd4;
      rem = rem - pl;
      n_tlp++;
    end
    for (int i = 0; i < pay.size(); i += 2) pend_q.push_back({pay[i], pay[i+1]});
  endtask

  // Apply last cycle's pop, let the producer refill, and pick this cycle's stall
  task automatic drive_inputs(input int stall_pct, input int empty_pct);
    logic [63:0] tmp;
    if (pop_pend) begin
      if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      pop_pend = 1'b0;
    end
    if (empty_pct == 0) begin
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    end else if (pend_q.size() > 0 && int'($urandom_range(99, 0)) >= empty_pct) begin
      fifo_q.push_back(pend_q.pop_front());
    end
    data_empty_i     = (fifo_q.size() == 0);
    data_i           = data_empty_i ? 64'hBAD0_BAD0_BAD0_BAD0 : fifo_q[0];
    trn_tdst_rdy_n_i = (stall_pct != 0) && (int'($urandom_range(99, 0)) < stall_pct);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    wdma_rst_o   = 1'b1;
    wdma_start_i = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    wdma_rst_o = 1'b0;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    pop_pend = 1'b0;
  endtask

  task automatic run_transfer(input logic [63:0] a, input int len, input int stall_pct,
                              input int empty_pct, input bit inject, output int n_tlp,
                              output int n_beats, output logic [63:0] first_td);
    int          model_tlps;
    int          done_cyc;
    bit          prev_held;
    logic [63:0] prev_td;
    logic [9:0]  prev_ctl;
    beat_t       b;
    build_model(a, len, model_tlps);
    n_beats   = 0;
    first_td  = 64'h0;
    done_cyc  = -1;
    prev_held = 1'b0;
    prev_td   = 64'h0;
    prev_ctl  = 10'h0;
    @(negedge clk);
    wdma_addr_i  = a;
    wdma_len_i   = 32'(len);
    wdma_start_i = 1'b1;
    drive_inputs(0, empty_pct);
    #1;
    chk("idle_src_rdy", {63'h0, trn_tsrc_rdy_n_o}, 64'h1);
    @(posedge clk);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      wdma_start_i = inject && (cyc == 10);
      if (inject && cyc == 10) begin
        wdma_addr_i = 64'h0000_0000_4000_0000;
        wdma_len_i  = 32'd2;
      end
      drive_inputs(stall_pct, empty_pct);
      #1;
      if (prev_held) begin
        chk("stall_src_rdy", {63'h0, trn_tsrc_rdy_n_o}, 64'h0);
        chk("stall_td", trn_td_o, prev_td);
        chk("stall_ctl", {54'h0, trn_trem_n_o, trn_tsof_n_o, trn_teof_n_o}, {54'h0, prev_ctl});
      end
      if (trn_tdst_rdy_n_i) chk("no_pop_stalled", {63'h0, data_rd_o}, 64'h0);
      if (data_empty_i) chk("no_pop_empty", {63'h0, data_rd_o}, 64'h0);
      if (!trn_tsrc_rdy_n_o && !trn_tdst_rdy_n_i) begin
        n_beats++;
        if (n_beats == 1) first_td = trn_td_o;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_beat: got td %h, expected no beat", trn_td_o);
        end else begin
          b = exp_q.pop_front();
          chk("beat_td", trn_td_o, b.td);
          chk("beat_ctl", {54'h0, trn_trem_n_o, trn_tsof_n_o, trn_teof_n_o},
              {54'h0, b.trem, b.sof, b.eof});
        end
      end
      prev_held = !trn_tsrc_rdy_n_o && trn_tdst_rdy_n_i;
      prev_td   = trn_td_o;
      prev_ctl  = {trn_trem_n_o, trn_tsof_n_o, trn_teof_n_o};
      pop_pend  = data_rd_o;
      if (wdma_done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    wdma_start_i = 1'b0;
    chk("done_seen", {63'h0, done_cyc >= 0}, 64'h1);
    chk("beats_left", 64'(exp_q.size()), 64'h0);
    chk("fifo_left", 64'(fifo_q.size() + pend_q.size()), 64'h0);
    chk("tlp_cnt_model", {48'h0, wdma_tlp_cnt_o}, 64'(model_tlps));
    if (len == 0) chk("len0_latency", 64'(done_cyc), 64'h0);
    n_tlp = int'(wdma_tlp_cnt_o);
    // Done holds, and a start in DONE is ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wdma_start_i = (i == 0);
      wdma_addr_i  = 64'h0000_0000_8000_0000;
      wdma_len_i   = 32'd8;
      drive_inputs(0, 0);
      #1;
      chk("done_hold", {62'h0, wdma_done_o, trn_tsrc_rdy_n_o}, 64'h3);
    end
    reset_dut();
  endtask

  vec_t        tbl[8];
  int          nt;
  int          nb;
  int          len;
  logic [63:0] ft;
  logic [31:0] hi;
  logic [31:0] lo;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h0000_0000_8000_0000, 64,  0,  0,  1'b0, 2, 36, 64'h4000_0020_BEEF_00FF};
    tbl[1] = '{64'h0000_0001_0000_0000, 8,   0,  0,  1'b0, 1, 6,  64'h6000_0008_BEEF_00FF};
    tbl[2] = '{64'h0000_0000_8000_0000, 34,  0,  0,  1'b0, 2, 21, 64'h4000_0020_BEEF_00FF};
    tbl[3] = '{64'h0000_0000_FFFF_FF80, 64,  0,  0,  1'b0, 2, 36, 64'h4000_0020_BEEF_00FF};
    tbl[4] = '{64'h0000_0000_8000_0000, 100, 30, 30, 1'b0, 4, 58, 64'h4000_0020_BEEF_00FF};
    tbl[5] = '{64'h0000_0002_0000_0000, 70,  30, 30, 1'b0, 3, 41, 64'h6000_0020_BEEF_00FF};
    tbl[6] = '{64'h0000_0000_8000_0100, 64,  20, 20, 1'b1, 2, 36, 64'h4000_0020_BEEF_00FF};
    tbl[7] = '{64'h0000_0000_8000_0000, 0,   0,  0,  1'b0, 0, 0,  64'h0};

    wdma_rst_o       = 1'b1;
    wdma_start_i     = 1'b0;
    wdma_addr_i      = 64'h0;
    wdma_len_i       = 32'h0;
    data_i           = 64'h0;
    data_empty_i     = 1'b1;
    trn_tdst_rdy_n_i = 1'b0;
    #2;
    check_reset_outputs("init");
    @(negedge clk);
    wdma_rst_o = 1'b0;

    // Directed table
    for (int t = 0; t < 8; t++) begin
      run_transfer(tbl[t].addr, tbl[t].len, tbl[t].stall, tbl[t].empty, tbl[t].inject, nt, nb, ft);
      chk($sformatf("vec%0d_tlps", t), 64'(nt), 64'(tbl[t].exp_tlps));
      chk($sformatf("vec%0d_beats", t), 64'(nb), 64'(tbl[t].exp_beats));
      chk($sformatf("vec%0d_first", t), ft, tbl[t].exp_first);
    end

    // Randomized transfers against the model
    for (int r = 0; r < 6; r++) begin
      hi  = ($urandom_range(1, 0) != 0) ? 32'($urandom_range(3, 1)) : 32'h0;
      lo  = $urandom & 32'hFFFF_FF80;
      len = 2 * int'($urandom_range(60, 0));
      run_transfer({hi, lo}, len, int'($urandom_range(40, 0)), int'($urandom_range(40, 0)),
                   1'b0, nt, nb, ft);
      chk("rand_tlps", 64'(nt), 64'((len + MPS - 1) / MPS));
    end

    // Reset in the middle of DATA: outputs drop at once, then a clean transfer
    build_model(64'h0000_0000_8000_0000, 64, nt);
    @(negedge clk);
    wdma_addr_i  = 64'h0000_0000_8000_0000;
    wdma_len_i   = 32'd64;
    wdma_start_i = 1'b1;
    drive_inputs(0, 0);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wdma_start_i = 1'b0;
      drive_inputs(0, 0);
      #1;
      pop_pend = data_rd_o;
    end
    @(negedge clk);
    drive_inputs(0, 0);
    #1;
    chk("mid_data_active", {62'h0, trn_tsrc_rdy_n_o, data_rd_o}, 64'h1);
    wdma_rst_o = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    wdma_rst_o = 1'b0;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    pop_pend = 1'b0;
    run_transfer(64'h0000_0001_0000_0000, 8, 0, 0, 1'b0, nt, nb, ft);
    chk("after_rst_tlps", 64'(nt), 64'h1);
    chk("after_rst_beats", 64'(nb), 64'h6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
